// File: rtl/io_stub_pkg.sv
// Shared definitions for the I/O stub family: FSM state encoding, wait
// counter width and register-index sizing.
package io_stub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_END  = 2'd3
    } io_state_t;

    localparam int CTR_W = 4;

    function automatic int log2_ceil(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/io_wait_ctr.sv
// Loadable down-counter that stops at zero; shared by the I/O and memory
// wait-state stubs.
module io_wait_ctr
    import io_stub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [CTR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/io_regfile_stub.sv
// Bank of NREGS 16-bit I/O registers on the CPU bus with word/byte access
// and a programmable wait-state acknowledge.
module io_regfile_stub
    import io_stub_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h00b0,
    parameter int          NREGS     = 8,
    parameter int          WAIT      = 2,
    parameter bit          ACK_MISS  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        mio_i,
    input  logic        byte_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic [15:0] reg0_o
);

    localparam int IDX_W = log2_ceil(NREGS);
    localparam logic [16:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [16:0] HI_ADDR = LO_ADDR + 17'(2 * NREGS);
    localparam logic [CTR_W-1:0] WAIT_LD = (WAIT == 0) ? '0 : CTR_W'(WAIT - 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             lane;
        logic             we;
        logic             byte_acc;
        logic [15:0]      dat;
        logic             hit;
    } req_t;

    io_state_t                  state;
    req_t                       req_in, req_q, req_nxt;
    logic [NREGS-1:0][15:0]     regs;
    logic [15:0]                rd_word, rd_nxt;
    logic                       hit, accept, ctr_load, ctr_zero;

    // 17-bit compare so a bank at the top of the I/O space cannot wrap.
    assign hit    = ({1'b0, adr_i} >= LO_ADDR) && ({1'b0, adr_i} < HI_ADDR);
    assign accept = stb_i && mio_i && (hit || ACK_MISS);

    assign req_in = '{idx:      adr_i[IDX_W:1],
                      lane:     adr_i[0],
                      we:       we_i,
                      byte_acc: byte_i,
                      dat:      dat_i,
                      hit:      hit};

    // With WAIT=0 the ACK entry happens straight from IDLE, before req_q is
    // loaded, so read data is taken from whichever request is current.
    always_comb begin
        req_nxt = (state == ST_IDLE) ? req_in : req_q;
        rd_word = regs[req_nxt.idx];
        rd_nxt  = '0;
        if (req_nxt.hit && !req_nxt.we)
            rd_nxt = req_nxt.byte_acc
                   ? {8'h00, (req_nxt.lane ? rd_word[15:8] : rd_word[7:0])}
                   : rd_word;
    end

    assign ctr_load = (state == ST_IDLE) && accept && (WAIT != 0);

    io_wait_ctr u_wait (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (ctr_load),
        .value (WAIT_LD),
        .en    (state == ST_WAIT),
        .zero  (ctr_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            ack_o <= 1'b0;
            dat_o <= '0;
            req_q <= '0;
        end else begin
            ack_o <= 1'b0;
            dat_o <= '0;
            case (state)
                ST_IDLE:
                    if (accept) begin
                        req_q <= req_in;
                        if (WAIT == 0) begin
                            state <= ST_ACK;
                            ack_o <= 1'b1;
                            dat_o <= rd_nxt;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                ST_WAIT:
                    if (ctr_zero) begin
                        state <= ST_ACK;
                        ack_o <= 1'b1;
                        dat_o <= rd_nxt;
                    end
                ST_ACK:
                    state <= ST_END;
                ST_END:
                    if (!stb_i)
                        state <= ST_IDLE;
            endcase
        end
    end

    // Writes commit in the ACK cycle, so a reset during WAIT drops them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs <= '0;
        end else if (state == ST_ACK && req_q.hit && req_q.we) begin
            if (!req_q.byte_acc)
                regs[req_q.idx] <= req_q.dat;
            else if (req_q.lane)
                regs[req_q.idx][15:8] <= req_q.dat[7:0];
            else
                regs[req_q.idx][7:0] <= req_q.dat[7:0];
        end
    end

    assign reg0_o = regs[0];

endmodule
